prbs31_checker: RTL and testbench
=================================

# prbs31_checker

Receive-side pattern checker for the SFP0 link test path. The GTH driver emits a PRBS-31 pattern on SFP0; this block sits on the recovered parallel receive data in the GTH receive clock domain. It self-synchronises to the incoming stream, declares lock, and counts bit errors and checked words for readback over the register bus. Together with the transmit-side generator, it allows link BER testing without the classical NIC.

## Interface
Parameters:
- LOCK_CNT, 16: consecutive matching words required, after the seed word, to enter LOCKED (legal range 1..255).
- UNLOCK_CNT, 4: consecutive mismatching words in LOCKED that force a return to SEARCH (legal range 1..255).

Ports:
- clk  in  1  GTH receive user clock; all logic is in this single clock domain.
- rst  in  1  asynchronous, active-high reset.
- rx_data  in  32  received word; bit 0 is the earliest bit in time.
- rx_vld  in  1  rx_data is valid this cycle; gaps are allowed.
- clr  in  1  synchronous clear of err_cnt, word_cnt and lol; lock state is unaffected.
- locked  out  1  high while the state machine is in LOCKED.
- err_pulse  out  1  one-cycle pulse for each checked word containing at least one bit error.
- err_cnt  out  32  saturating count of bit errors.
- word_cnt  out  32  saturating count of checked words.
- lol  out  1  sticky loss-of-lock flag; set on any LOCKED to SEARCH transition.

## Operation
- Sequence definition: b[k] = b[k-31] XOR b[k-28] (x^31 + x^28 + 1).
- Prediction function: pred = next32(ref) applies the recurrence 32 times using bits ref[31:0] as b[n..n+31]. The result is bits n+32..n+63, with LSB first.
- Internal state:
  - ref, 32 bits;
  - state: SEARCH, VERIFY or LOCKED;
  - good_cnt, 8 bits;
  - bad_cnt, 8 bits.
- Nothing changes on cycles with rx_vld=0, except that clr is still honoured.
- On each accepted word W (rx_vld=1):
  - SEARCH:
    - if W != 0: ref <= W, good_cnt <= 0, go to VERIFY;
    - otherwise stay in SEARCH.
  - VERIFY:
    - if W == pred and W != 0: good_cnt++; when the new value equals LOCK_CNT, go to LOCKED with bad_cnt <= 0;
    - otherwise good_cnt <= 0; if W == 0 go to SEARCH, else stay in VERIFY.
    - In both cases ref <= W (self-synchronous reseed).
  - LOCKED:
    - ref <= pred (free-running), so one corrupted word does not propagate errors into the next prediction;
    - if W == pred: bad_cnt <= 0;
    - otherwise bad_cnt++; when the new value equals UNLOCK_CNT, go to SEARCH and set lol <= 1.
- The all-zero word never counts as a match. This prevents a false lock on a dead or zeroed link.
- Checking pipeline: at the edge that accepts W while in LOCKED, register diff_q <= W ^ pred and chk_q <= 1. On every other edge, chk_q <= 0.
- Counters update one edge after the accepting edge:
  - word_cnt += chk_q;
  - err_cnt += popcount(diff_q) when chk_q=1 (popcount range 0..32).
  - Both saturate at 0xFFFFFFFF and never wrap.
- The word that causes the LOCKED to SEARCH transition is still checked and counted. The word that completes VERIFY is not counted.
- clr wins over a simultaneous increment: the counter becomes 0. It also wins over a simultaneous lol set: lol becomes 0.
- lol is set only by a LOCKED to SEARCH transition and cleared only by clr or rst.

## Timing
- Reset values (asynchronous, immediate): state=SEARCH, ref=0, good_cnt=0, bad_cnt=0, chk_q=0, diff_q=0. All outputs are 0: locked, err_pulse, err_cnt, word_cnt, lol.
- Edge E accepts W. At E:
  - state, ref, good_cnt and bad_cnt update;
  - locked (registered from state) reflects the new state in the cycle after E.
- At E+1:
  - err_pulse <= chk_q & (diff_q != 0);
  - err_cnt and word_cnt update.
  - Latency from rx_data to err_pulse/counters is therefore 2 clocks.
- Minimum lock time on a continuous clean stream: LOCK_CNT+1 accepted words. The first accepted word seeds ref; locked is high after the edge accepting word LOCK_CNT+1.
- Minimum unlock time: UNLOCK_CNT consecutive bad accepted words. locked is low after the edge accepting the last one. Good words between bad ones reset bad_cnt.
- Reset asserted mid-operation aborts any pipeline contents; no pulse or count is emitted for words in flight.
- Throughput: one word per clock, with no back-pressure.

## Test plan
- Clean stream, seed 0x7FFFFFFF, rx_vld=1 continuously, defaults -> locked rises after word 17; err_cnt=0 and word_cnt=1000 after 1000 further words; lol=0.
- While locked, XOR one word with 0x00000021 -> exactly one err_pulse 2 clocks later; err_cnt=2; the following word produces no error; locked stays 1.
- Four consecutive words corrupted with 0xFFFFFFFF -> err_cnt=128; locked falls after the 4th; lol=1; a clean continuation re-locks after 17 words.
- rx_data=0 held, rx_vld=1 for 1000 cycles -> locked never asserts; counters stay 0.
- Clean stream with random 50% rx_vld gaps -> lock after 17 accepted words; no errors; word_cnt equals the number of accepted words after lock.
- clr asserted in the same cycle as a counter update from a 3-bit error -> err_cnt=0 and word_cnt=0 next cycle; rst mid-lock -> all outputs 0 immediately.

Source files
------------

// File: rtl/prbs31_checker.sv
// rtl/prbs31_checker.sv - PRBS-31 receive checker: self-synchronising lock FSM plus error/word counters
module prbs31_checker #(
    parameter int LOCK_CNT   = 16,
    parameter int UNLOCK_CNT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] rx_data,
    input  logic        rx_vld,
    input  logic        clr,
    output logic        locked,
    output logic        err_pulse,
    output logic [31:0] err_cnt,
    output logic [31:0] word_cnt,
    output logic        lol
);

    typedef enum logic [1:0] {ST_SEARCH, ST_VERIFY, ST_LOCKED} state_t;

    localparam logic [7:0] LOCK_TGT   = 8'(LOCK_CNT);
    localparam logic [7:0] UNLOCK_TGT = 8'(UNLOCK_CNT);

    // Bits of ref are b[n..n+31]; the result is b[n+32..n+63], LSB earliest.
    function automatic logic [31:0] next32(input logic [31:0] seed);
        logic [63:0] s;
        s = {32'd0, seed};
        for (int j = 0; j < 32; j++) begin
            s[32+j] = s[j+1] ^ s[j+4];
        end
        return s[63:32];
    endfunction

    state_t      r_state, w_state_nxt;
    logic [31:0] r_ref, w_ref_nxt;
    logic [7:0]  r_good, w_good_nxt;
    logic [7:0]  r_bad, w_bad_nxt;
    logic        w_lol_set;
    logic [31:0] w_pred;
    logic        w_match;

    logic        r_chk;
    logic [31:0] r_diff;
    logic        r_err_pulse;
    logic [31:0] r_err_cnt;
    logic [31:0] r_word_cnt;
    logic        r_lol;
    logic [5:0]  w_pop;
    logic [32:0] w_err_sum;

    assign w_pred  = next32(r_ref);
    assign w_match = (rx_data == w_pred) && (rx_data != 32'd0);

    always_comb begin
        w_state_nxt = r_state;
        w_ref_nxt   = r_ref;
        w_good_nxt  = r_good;
        w_bad_nxt   = r_bad;
        w_lol_set   = 1'b0;
        if (rx_vld) begin
            case (r_state)
                ST_SEARCH: begin
                    if (rx_data != 32'd0) begin
                        w_ref_nxt   = rx_data;
                        w_good_nxt  = 8'd0;
                        w_state_nxt = ST_VERIFY;
                    end
                end
                ST_VERIFY: begin
                    w_ref_nxt = rx_data;
                    if (w_match) begin
                        w_good_nxt = r_good + 8'd1;
                        if (r_good + 8'd1 == LOCK_TGT) begin
                            w_state_nxt = ST_LOCKED;
                            w_bad_nxt   = 8'd0;
                        end
                    end else begin
                        w_good_nxt = 8'd0;
                        if (rx_data == 32'd0) begin
                            w_state_nxt = ST_SEARCH;
                        end
                    end
                end
                ST_LOCKED: begin
                    // Free-running prediction keeps a single bad word from poisoning the next one
                    w_ref_nxt = w_pred;
                    if (w_match) begin
                        w_bad_nxt = 8'd0;
                    end else begin
                        w_bad_nxt = r_bad + 8'd1;
                        if (r_bad + 8'd1 == UNLOCK_TGT) begin
                            w_state_nxt = ST_SEARCH;
                            w_lol_set   = 1'b1;
                        end
                    end
                end
                default: w_state_nxt = ST_SEARCH;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_SEARCH;
            r_ref   <= 32'd0;
            r_good  <= 8'd0;
            r_bad   <= 8'd0;
            r_chk   <= 1'b0;
            r_diff  <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            r_ref   <= w_ref_nxt;
            r_good  <= w_good_nxt;
            r_bad   <= w_bad_nxt;
            r_chk   <= rx_vld && (r_state == ST_LOCKED);
            if (rx_vld && (r_state == ST_LOCKED)) begin
                r_diff <= rx_data ^ w_pred;
            end
        end
    end

    always_comb begin
        w_pop = 6'd0;
        for (int i = 0; i < 32; i++) begin
            w_pop = w_pop + 6'(r_diff[i]);
        end
    end

    assign w_err_sum = {1'b0, r_err_cnt} + {27'd0, w_pop};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_pulse <= 1'b0;
            r_err_cnt   <= 32'd0;
            r_word_cnt  <= 32'd0;
            r_lol       <= 1'b0;
        end else begin
            r_err_pulse <= r_chk && (r_diff != 32'd0);
            if (clr) begin
                r_err_cnt  <= 32'd0;
                r_word_cnt <= 32'd0;
                r_lol      <= 1'b0;
            end else begin
                if (r_chk) begin
                    r_err_cnt  <= w_err_sum[32] ? 32'hFFFF_FFFF : w_err_sum[31:0];
                    r_word_cnt <= (r_word_cnt == 32'hFFFF_FFFF) ? r_word_cnt : r_word_cnt + 32'd1;
                end
                if (w_lol_set) begin
                    r_lol <= 1'b1;
                end
            end
        end
    end

    assign locked    = (r_state == ST_LOCKED);
    assign err_pulse = r_err_pulse;
    assign err_cnt   = r_err_cnt;
    assign word_cnt  = r_word_cnt;
    assign lol       = r_lol;

endmodule

// File: tb/tb_prbs31_checker.sv
// tb/tb_prbs31_checker.sv - directed and randomized checks of prbs31_checker against a bit-serial model
module tb_prbs31_checker;

    localparam int LOCK_CNT   = 16;
    localparam int UNLOCK_CNT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] rx_data;
    logic        rx_vld;
    logic        clr;
    logic        locked;
    logic        err_pulse;
    logic [31:0] err_cnt;
    logic [31:0] word_cnt;
    logic        lol;

    prbs31_checker #(.LOCK_CNT(LOCK_CNT), .UNLOCK_CNT(UNLOCK_CNT)) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_data  (rx_data),
        .rx_vld   (rx_vld),
        .clr      (clr),
        .locked   (locked),
        .err_pulse(err_pulse),
        .err_cnt  (err_cnt),
        .word_cnt (word_cnt),
        .lol      (lol)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Model: hunting (no seed), verifying (seeded, counting good), or tracking (locked)
    localparam int HUNT = 0, VERIFY = 1, TRACK = 2;
    int          m_phase;
    logic [31:0] m_last;
    int          m_good, m_bad;
    bit          m_pend;
    logic [31:0] m_pend_diff;
    bit          m_pulse, m_lol;
    longint      m_err, m_word;
    logic [31:0] tx;

    // Extend the bit sequence 32 steps with b[k] = b[k-31] ^ b[k-28]
    function automatic logic [31:0] prbs_next(input logic [31:0] w);
        bit s[$];
        logic [31:0] r;
        for (int i = 0; i < 32; i++) s.push_back(w[i]);
        for (int i = 0; i < 32; i++) s.push_back(s[s.size()-31] ^ s[s.size()-28]);
        for (int i = 0; i < 32; i++) r[i] = s[32+i];
        return r;
    endfunction

    function automatic longint sat32(input longint x);
        return (x > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : x;
    endfunction

    task automatic model_reset();
        m_phase = HUNT; m_last = 32'd0; m_good = 0; m_bad = 0;
        m_pend = 0; m_pend_diff = 32'd0; m_pulse = 0; m_lol = 0;
        m_err = 0; m_word = 0;
    endtask

    task automatic model_edge(input logic [31:0] d, input logic v, input logic c);
        logic [31:0] pred;
        bit          hit;
        bit          nxt_pend;
        m_pulse = m_pend && (m_pend_diff != 32'd0);
        if (m_pend) begin
            m_word = sat32(m_word + 1);
            m_err  = sat32(m_err + $countones(m_pend_diff));
        end
        nxt_pend = 0;
        if (v) begin
            pred = prbs_next(m_last);
            hit  = (d == pred) && (d != 32'd0);
            if (m_phase == HUNT) begin
                if (d != 32'd0) begin m_last = d; m_good = 0; m_phase = VERIFY; end
            end else if (m_phase == VERIFY) begin
                m_last = d;
                if (hit) begin
                    m_good++;
                    if (m_good == LOCK_CNT) begin m_phase = TRACK; m_bad = 0; end
                end else begin
                    m_good = 0;
                    if (d == 32'd0) m_phase = HUNT;
                end
            end else begin
                nxt_pend = 1; m_pend_diff = d ^ pred; m_last = pred;
                if (hit) m_bad = 0;
                else begin
                    m_bad++;
                    if (m_bad == UNLOCK_CNT) begin m_phase = HUNT; m_lol = 1; end
                end
            end
        end
        m_pend = nxt_pend;
        if (c) begin m_err = 0; m_word = 0; m_lol = 0; end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("locked", {31'd0, locked}, {31'd0, m_phase == TRACK});
        chk("err_pulse", {31'd0, err_pulse}, {31'd0, m_pulse});
        chk("err_cnt", err_cnt, m_err[31:0]);
        chk("word_cnt", word_cnt, m_word[31:0]);
        chk("lol", {31'd0, lol}, {31'd0, m_lol});
    endtask

    task automatic tick(input logic [31:0] d, input logic v, input logic c);
        rx_data = d; rx_vld = v; clr = c;
        model_edge(d, v, c);
        @(negedge clk);
        check_all();
    endtask

    task automatic send_clean(input int n);
        for (int i = 0; i < n; i++) begin
            tick(tx, 1'b1, 1'b0);
            tx = prbs_next(tx);
        end
    endtask

    task automatic hard_reset();
        rst = 1'b1; rx_vld = 1'b0; clr = 1'b0; rx_data = 32'd0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    int accepted, lock_at;
    bit seen;

    initial begin
        rst = 1'b1; rx_data = 32'd0; rx_vld = 1'b0; clr = 1'b0;
        hard_reset();
        check_all();
        chk("reset_err_cnt", err_cnt, 32'd0);
        chk("reset_locked", {31'd0, locked}, 32'd0);

        // Clean continuous stream: lock on word LOCK_CNT+1
        tx = 32'h7FFF_FFFF;
        send_clean(LOCK_CNT);
        chk("no_lock_at_16", {31'd0, locked}, 32'd0);
        send_clean(1);
        chk("lock_at_17", {31'd0, locked}, 32'd1);
        send_clean(1000);
        tick(32'd0, 1'b0, 1'b0);
        chk("clean_err_cnt", err_cnt, 32'd0);
        chk("clean_word_cnt", word_cnt, 32'd1000);
        chk("clean_lol", {31'd0, lol}, 32'd0);

        // Single corrupted word: two-bit error, pulse two clocks later
        tick(tx ^ 32'h0000_0021, 1'b1, 1'b0); tx = prbs_next(tx);
        send_clean(1);
        chk("single_pulse", {31'd0, err_pulse}, 32'd1);
        send_clean(1);
        chk("single_no_followon", {31'd0, err_pulse}, 32'd0);
        tick(32'd0, 1'b0, 1'b0);
        chk("single_err_cnt", err_cnt, 32'd2);
        chk("single_locked", {31'd0, locked}, 32'd1);

        // Four fully inverted words force unlock, then re-lock
        tick(32'd0, 1'b0, 1'b1);
        for (int i = 0; i < UNLOCK_CNT; i++) begin
            tick(~tx, 1'b1, 1'b0); tx = prbs_next(tx);
            if (i == UNLOCK_CNT - 2) chk("still_locked_3", {31'd0, locked}, 32'd1);
        end
        chk("unlock_after_4", {31'd0, locked}, 32'd0);
        chk("lol_set", {31'd0, lol}, 32'd1);
        tick(32'd0, 1'b0, 1'b0);
        chk("burst_err_cnt", err_cnt, 32'd128);
        send_clean(LOCK_CNT);
        chk("relock_not_yet", {31'd0, locked}, 32'd0);
        send_clean(1);
        chk("relock_17", {31'd0, locked}, 32'd1);

        // Dead link of zeros must never lock
        hard_reset();
        for (int i = 0; i < 1000; i++) tick(32'd0, 1'b1, 1'b0);
        chk("zero_locked", {31'd0, locked}, 32'd0);
        chk("zero_word_cnt", word_cnt, 32'd0);
        chk("zero_err_cnt", err_cnt, 32'd0);

        // Random rx_vld gaps with garbage on idle cycles
        hard_reset();
        tx = 32'h7FFF_FFFF; accepted = 0; seen = 0; lock_at = 0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                tick(tx, 1'b1, 1'b0); tx = prbs_next(tx); accepted++;
                if (!seen && locked) begin seen = 1; lock_at = accepted; end
            end else begin
                tick($urandom, 1'b0, 1'b0);
            end
        end
        tick(32'd0, 1'b0, 1'b0);
        chk("gap_lock_at", lock_at, 32'd17);
        chk("gap_word_cnt", word_cnt, 32'(accepted - 17));
        chk("gap_err_cnt", err_cnt, 32'd0);

        // clr coincides with the update from a 3-bit error
        tick(tx ^ 32'h0000_0007, 1'b1, 1'b0); tx = prbs_next(tx);
        tick(tx, 1'b1, 1'b1); tx = prbs_next(tx);
        chk("clr_err_cnt", err_cnt, 32'd0);
        chk("clr_word_cnt", word_cnt, 32'd0);
        send_clean(5);

        // Asynchronous reset mid-lock
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("arst_locked", {31'd0, locked}, 32'd0);
        chk("arst_err_pulse", {31'd0, err_pulse}, 32'd0);
        chk("arst_err_cnt", err_cnt, 32'd0);
        chk("arst_word_cnt", word_cnt, 32'd0);
        chk("arst_lol", {31'd0, lol}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        send_clean(LOCK_CNT + 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
